// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the memory stage: datapath width, funct3 access
// size codes, stage state encoding and an access-size helper.
package riscv_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_WB
  } mem_state_t;

  // Low-address-bit mask of an access; size is funct3[1:0], so 111 behaves as D.
  function automatic logic [2:0] size_mask(input logic [1:0] f3_size);
    case (f3_size)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed lane of a 64-bit read word and
// sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_value
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_value = w_shifted;
    case (i_funct3)
      F3_B:    o_value = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    o_value = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_value = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_BU:   o_value = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      F3_HU:   o_value = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      F3_WU:   o_value = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_value = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: one outstanding valid/ready data-memory access,
// load alignment and a single writeback record. Option: MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_data,
  input  logic [4:0]      ex_dest,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_dest,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_exc
);

  mem_state_t      r_state;
  mem_state_t      w_next;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_store_data;
  logic [XLEN-1:0] r_wb_data;
  logic [4:0]      r_dest;
  logic            r_is_load;
  logic            r_is_store;
  logic [2:0]      r_funct3;
  logic            r_trap;

  logic            w_accept;
  logic            w_ex_mem;
  logic            w_ex_trap;
  logic [2:0]      w_off;
  logic [XLEN-1:0] w_load_val;
  logic [7:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;

  assign w_accept = (r_state == ST_IDLE) && ex_valid;
  assign w_ex_mem = ex_is_load || ex_is_store;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_ex_trap    = w_ex_mem && ((ex_data[2:0] & size_mask(ex_funct3[1:0])) != 3'b000);
  assign misalign_exc = (r_state == ST_WB) && r_trap;
`else
  assign w_ex_trap    = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  // Bits below the access size are dropped so a misaligned access stays inside its word.
  assign w_off = r_addr[2:0] & ~size_mask(r_funct3[1:0]);

  load_align u_load_align (
    .i_rdata  (mem_rdata),
    .i_offset (w_off),
    .i_funct3 (r_funct3),
    .o_value  (w_load_val)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (ex_valid) w_next = (!w_ex_mem || w_ex_trap) ? ST_WB : ST_REQ;
      ST_REQ:  if (mem_req_ready) w_next = ST_RESP;
      ST_RESP: if (mem_resp_valid) w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wstrb = '0;
    w_wdata = '0;
    if (r_is_store) begin
      case (r_funct3[1:0])
        2'b00:   w_wstrb = 8'h01 << w_off;
        2'b01:   w_wstrb = 8'h03 << w_off;
        2'b10:   w_wstrb = 8'h0F << w_off;
        default: w_wstrb = 8'hFF;
      endcase
      w_wdata = r_store_data << {w_off, 3'b000};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_store_data <= '0;
      r_wb_data    <= '0;
      r_dest       <= '0;
      r_is_load    <= 1'b0;
      r_is_store   <= 1'b0;
      r_funct3     <= '0;
      r_trap       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr       <= ex_data;
        r_store_data <= ex_store_data;
        r_dest       <= ex_dest;
        r_is_load    <= ex_is_load;
        r_is_store   <= ex_is_store;
        r_funct3     <= ex_funct3;
        r_trap       <= w_ex_trap;
        r_wb_data    <= w_ex_mem ? '0 : ex_data;
      end else if ((r_state == ST_RESP) && mem_resp_valid) begin
        r_wb_data <= r_is_store ? '0 : w_load_val;
      end
    end
  end

  assign ex_ready      = (r_state == ST_IDLE);
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_addr      = {r_addr[XLEN-1:3], 3'b000};
  assign mem_we        = r_is_store;
  assign mem_wdata     = w_wdata;
  assign mem_wstrb     = w_wstrb;
  assign wb_valid      = (r_state == ST_WB);
  assign wb_en         = (r_state == ST_WB) && !r_trap && !r_is_store && (r_dest != 5'd0);
  assign wb_dest       = r_dest;
  assign wb_data       = r_wb_data;

endmodule
